// File: rtl/text_char_buffer_if.sv
// ----------------------------------------------------------------------------
// text_char_buffer_if
// Character stream handshake into the text character buffer.
//   char_in    : ASCII code offered by the producer
//   char_valid : char_in is valid this cycle
//   char_ready : buffer accepts char_in this cycle
// A transfer happens on a rising edge where char_valid && char_ready.
// ----------------------------------------------------------------------------
interface text_char_buffer_if;
   logic [7:0] char_in;
   logic       char_valid;
   logic       char_ready;

   modport master (output char_in, output char_valid, input  char_ready);
   modport slave  (input  char_in, input  char_valid, output char_ready);
endinterface

// File: rtl/text_char_buffer.sv
// ----------------------------------------------------------------------------
// text_char_buffer
// Stores an ASCII character stream in a COLS x ROWS cell RAM with a cursor
// (wrap, newline, backspace, clear) and returns, for each VGA pixel, the
// character of the covering cell plus that cell's top-left corner.
// Ports:
//   VGA_clk, resetn       : pixel clock, async active-low reset
//   chr (slave)           : char_in / char_valid / char_ready handshake
//   xPixel, yPixel        : current pixel coordinate
//   ascii_val             : character at pixel's cell (0 outside active area)
//   xStart, yStart        : cell origin (0 outside active area)
//   cursor_col/cursor_row : current cursor position
//   busy                  : RAM clear in progress
// Pixel path latency is two clocks and independent of the write FSM.
// ----------------------------------------------------------------------------
module text_char_buffer #(
   parameter int unsigned CELL_LOG2 = 5,
   parameter int unsigned COLS      = 20,
   parameter int unsigned ROWS      = 15,
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned V_ACTIVE  = 480
) (
   input  logic               VGA_clk,
   input  logic               resetn,
   text_char_buffer_if.slave  chr,
   input  logic [9:0]         xPixel,
   input  logic [9:0]         yPixel,
   output logic [7:0]         ascii_val,
   output logic [9:0]         xStart,
   output logic [9:0]         yStart,
   output logic [4:0]         cursor_col,
   output logic [3:0]         cursor_row,
   output logic               busy
);

   localparam int unsigned CELLS  = COLS * ROWS;
   localparam int unsigned ADDR_W = $clog2(CELLS);
   localparam int unsigned PIX_W  = 10;
   localparam int unsigned CPIX_W = PIX_W - CELL_LOG2;
   localparam int unsigned COL_W  = 5;
   localparam int unsigned ROW_W  = 4;

   typedef enum logic {S_CLEAR, S_IDLE} state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   clr_addr_q;
   logic [COL_W-1:0]    col_q;
   logic [ROW_W-1:0]    row_q;
   logic                ready_q;
   logic                busy_q;

   logic [7:0]          mem_q [CELLS];

   logic [CPIX_W-1:0]   pcol_q;
   logic [CPIX_W-1:0]   prow_q;
   logic                in_area_q;
   logic [7:0]          ascii_q;
   logic [PIX_W-1:0]    xstart_q;
   logic [PIX_W-1:0]    ystart_q;

   logic                xfer_c;
   logic                printable_c;
   logic                at_origin_c;
   logic                last_col_c;
   logic                last_row_c;
   logic [COL_W-1:0]    adv_col_c;
   logic [ROW_W-1:0]    adv_row_c;
   logic [ROW_W-1:0]    nl_row_c;
   logic [COL_W-1:0]    bs_col_c;
   logic [ROW_W-1:0]    bs_row_c;
   logic [ADDR_W-1:0]   cur_addr_c;
   logic                we_c;
   logic [ADDR_W-1:0]   waddr_c;
   logic [7:0]          wdata_c;
   logic [ADDR_W-1:0]   rd_addr_c;

   // Handshake decode and cursor candidates
   always_comb begin
      xfer_c      = chr.char_valid && ready_q;
      printable_c = (chr.char_in >= 8'h20) && (chr.char_in <= 8'h7E);
      at_origin_c = (col_q == '0) && (row_q == '0);
      last_col_c  = (col_q == COL_W'(COLS - 1));
      last_row_c  = (row_q == ROW_W'(ROWS - 1));
      nl_row_c    = last_row_c ? '0 : row_q + ROW_W'(1);
      adv_col_c   = last_col_c ? '0 : col_q + COL_W'(1);
      adv_row_c   = last_col_c ? nl_row_c : row_q;
      bs_col_c    = (col_q == '0) ? COL_W'(COLS - 1) : col_q - COL_W'(1);
      bs_row_c    = (col_q == '0) ? row_q - ROW_W'(1) : row_q;
      cur_addr_c  = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
   end

   // Write port: clear sweep, printable store, or backspace erase
   always_comb begin
      we_c    = 1'b0;
      waddr_c = clr_addr_q;
      wdata_c = 8'h20;
      if (state_q == S_CLEAR) begin
         we_c = 1'b1;
      end else if (xfer_c) begin
         if (printable_c) begin
            we_c    = 1'b1;
            waddr_c = cur_addr_c;
            wdata_c = chr.char_in;
         end else if ((chr.char_in == 8'h08) && !at_origin_c) begin
            // Previous cell in row-major order is simply the linear address minus one
            we_c    = 1'b1;
            waddr_c = cur_addr_c - ADDR_W'(1);
         end
      end
   end

   // Control FSM with registered handshake/status outputs
   always_ff @(posedge VGA_clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_CLEAR;
         clr_addr_q <= '0;
         col_q      <= '0;
         row_q      <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            S_CLEAR: begin
               if (clr_addr_q == ADDR_W'(CELLS - 1)) begin
                  state_q    <= S_IDLE;
                  clr_addr_q <= '0;
                  col_q      <= '0;
                  row_q      <= '0;
                  ready_q    <= 1'b1;
                  busy_q     <= 1'b0;
               end else begin
                  clr_addr_q <= clr_addr_q + ADDR_W'(1);
               end
            end
            S_IDLE: begin
               if (xfer_c) begin
                  if (printable_c) begin
                     col_q <= adv_col_c;
                     row_q <= adv_row_c;
                  end else if (chr.char_in == 8'h0A) begin
                     col_q <= '0;
                     row_q <= nl_row_c;
                  end else if (chr.char_in == 8'h08) begin
                     if (!at_origin_c) begin
                        col_q <= bs_col_c;
                        row_q <= bs_row_c;
                     end
                  end else if (chr.char_in == 8'h0C) begin
                     state_q    <= S_CLEAR;
                     clr_addr_q <= '0;
                     ready_q    <= 1'b0;
                     busy_q     <= 1'b1;
                  end
               end
            end
            default: state_q <= S_CLEAR;
         endcase
      end
   end

   // Character RAM write port (contents not reset; CLEAR erases them)
   always_ff @(posedge VGA_clk) begin
      if (we_c) mem_q[waddr_c] <= wdata_c;
   end

   // Out-of-area coordinates map outside the RAM, so steer them to address 0
   always_comb begin
      rd_addr_c = in_area_q ? (ADDR_W'(prow_q) * ADDR_W'(COLS) + ADDR_W'(pcol_q)) : '0;
   end

   // Pixel path: stage 1 cell coordinates, stage 2 RAM read and cell origin
   always_ff @(posedge VGA_clk or negedge resetn) begin
      if (!resetn) begin
         pcol_q    <= '0;
         prow_q    <= '0;
         in_area_q <= 1'b0;
         ascii_q   <= '0;
         xstart_q  <= '0;
         ystart_q  <= '0;
      end else begin
         pcol_q    <= CPIX_W'(xPixel >> CELL_LOG2);
         prow_q    <= CPIX_W'(yPixel >> CELL_LOG2);
         in_area_q <= (xPixel < PIX_W'(H_ACTIVE)) && (yPixel < PIX_W'(V_ACTIVE));
         ascii_q   <= in_area_q ? mem_q[rd_addr_c] : 8'h00;
         xstart_q  <= in_area_q ? PIX_W'({pcol_q, {CELL_LOG2{1'b0}}}) : '0;
         ystart_q  <= in_area_q ? PIX_W'({prow_q, {CELL_LOG2{1'b0}}}) : '0;
      end
   end

   assign chr.char_ready = ready_q;
   assign busy           = busy_q;
   assign cursor_col     = col_q;
   assign cursor_row     = row_q;
   assign ascii_val      = ascii_q;
   assign xStart         = xstart_q;
   assign yStart         = ystart_q;

endmodule

// File: tb/tb_text_char_buffer.sv
// ----------------------------------------------------------------------------
// tb_text_char_buffer
// Randomized stimulus against a linear-position reference model of the
// character screen. Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_text_char_buffer;

   localparam int COLS  = 20;
   localparam int ROWS  = 15;
   localparam int CELLS = COLS * ROWS;
   localparam int CELL  = 32;

   logic       VGA_clk = 1'b0;
   logic       resetn;
   logic [9:0] xPixel, yPixel;
   logic [7:0] ascii_val;
   logic [9:0] xStart, yStart;
   logic [4:0] cursor_col;
   logic [3:0] cursor_row;
   logic       busy;

   text_char_buffer_if cif ();

   text_char_buffer dut (
      .VGA_clk    (VGA_clk),
      .resetn     (resetn),
      .chr        (cif),
      .xPixel     (xPixel),
      .yPixel     (yPixel),
      .ascii_val  (ascii_val),
      .xStart     (xStart),
      .yStart     (yStart),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   always #5 VGA_clk = ~VGA_clk;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] model_mem [CELLS];
   int         mcol = 0;
   int         mrow = 0;
   logic [7:0] others [6] = '{8'h00, 8'h7F, 8'h9B, 8'hFF, 8'h1B, 8'h0D};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < CELLS; i++) model_mem[i] = 8'h20;
      mcol = 0;
      mrow = 0;
   endtask

   // Screen as a linear row-major array of cells
   task automatic model_apply(input logic [7:0] c);
      int pos;
      pos = mrow * COLS + mcol;
      if (c >= 8'h20 && c <= 8'h7E) begin
         model_mem[pos] = c;
         pos = (pos + 1) % CELLS;
         mrow = pos / COLS;
         mcol = pos % COLS;
      end else if (c == 8'h0A) begin
         mcol = 0;
         mrow = (mrow + 1) % ROWS;
      end else if (c == 8'h08 && pos > 0) begin
         pos = pos - 1;
         model_mem[pos] = 8'h20;
         mrow = pos / COLS;
         mcol = pos % COLS;
      end
   endtask

   task automatic check_cursor(input string tag);
      chk({tag, "_col"}, 32'(cursor_col), 32'(mcol));
      chk({tag, "_row"}, 32'(cursor_row), 32'(mrow));
   endtask

   // Waits out a clear from a falling edge where char_ready is low
   task automatic wait_clear(input bit hold);
      int n;
      n = 0;
      if (hold) begin
         cif.char_in    = 8'h5A;
         cif.char_valid = 1'b1;
      end
      while (cif.char_ready !== 1'b1 && n < 400) begin
         @(negedge VGA_clk);
         n++;
      end
      chk("clear_cycles", 32'(n), 32'd300);
      chk("busy_after_clear", 32'(busy), 32'd0);
      model_clear();
      check_cursor("clear_cur");
      if (hold) begin
         @(posedge VGA_clk);
         model_apply(8'h5A);
         @(negedge VGA_clk);
         cif.char_valid = 1'b0;
         check_cursor("hold_cur");
      end
   endtask

   task automatic send_char(input logic [7:0] c, input bit hold = 1'b0);
      cif.char_in    = c;
      cif.char_valid = 1'b1;
      chk("ready_before_xfer", 32'(cif.char_ready), 32'd1);
      @(posedge VGA_clk);
      if (c != 8'h0C) model_apply(c);
      @(negedge VGA_clk);
      cif.char_valid = 1'b0;
      cif.char_in    = 8'($urandom);
      if (c == 8'h0C) begin
         chk("ready_drop", 32'(cif.char_ready), 32'd0);
         wait_clear(hold);
      end else begin
         check_cursor("cur");
      end
   endtask

   task automatic read_pixel(input int x, input int y);
      bit in_area;
      xPixel = 10'(x);
      yPixel = 10'(y);
      @(posedge VGA_clk);
      @(posedge VGA_clk);
      @(negedge VGA_clk);
      in_area = (x < 640) && (y < 480);
      chk("ascii_val", 32'(ascii_val), in_area ? 32'(model_mem[(y / CELL) * COLS + x / CELL]) : 32'd0);
      chk("xStart", 32'(xStart), in_area ? 32'((x / CELL) * CELL) : 32'd0);
      chk("yStart", 32'(yStart), in_area ? 32'((y / CELL) * CELL) : 32'd0);
   endtask

   task automatic check_all();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            read_pixel(c * CELL + $urandom_range(0, 31), r * CELL + $urandom_range(0, 31));
   endtask

   function automatic logic [7:0] rand_char();
      int k;
      k = $urandom_range(0, 9);
      if (k <= 6)      return 8'($urandom_range(32, 126));
      else if (k == 7) return 8'h0A;
      else if (k == 8) return 8'h08;
      else             return others[$urandom_range(0, 5)];
   endfunction

   initial begin
      resetn         = 1'b0;
      cif.char_in    = 8'h00;
      cif.char_valid = 1'b0;
      xPixel         = '0;
      yPixel         = '0;
      model_clear();

      // Reset state and power-up clear
      @(negedge VGA_clk);
      @(negedge VGA_clk);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_ready", 32'(cif.char_ready), 32'd0);
      chk("rst_ascii", 32'(ascii_val), 32'd0);
      chk("rst_xstart", 32'(xStart), 32'd0);
      chk("rst_ystart", 32'(yStart), 32'd0);
      check_cursor("rst_cur");
      resetn = 1'b1;
      wait_clear(1'b0);
      check_all();

      // Single character
      send_char(8'h4D);
      read_pixel(5, 3);
      chk("M_cur_col", 32'(cursor_col), 32'd1);

      // Row wrap after a full row
      send_char(8'h0C);
      for (int i = 0; i < 20; i++) send_char(8'h41);
      send_char(8'h42);
      read_pixel(10, 40);
      chk("wrap_cur_row", 32'(cursor_row), 32'd1);

      // Backspace across a row boundary, then at origin
      send_char(8'h0C);
      send_char(8'h0A);
      send_char(8'h08);
      chk("bs_cur_col", 32'(cursor_col), 32'd19);
      read_pixel(19 * CELL + 4, 4);
      send_char(8'h0C);
      send_char(8'h08);
      read_pixel(2, 2);

      // Random traffic with idle gaps and spot reads
      for (int i = 0; i < 400; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge VGA_clk);
         send_char(rand_char());
         if ($urandom_range(0, 7) == 0)
            read_pixel($urandom_range(0, 1023), $urandom_range(0, 1023));
      end
      check_all();

      // Fill every cell, wrap to origin, then clear with char_valid held
      send_char(8'h0C);
      for (int i = 0; i < CELLS; i++) send_char(8'($urandom_range(33, 126)));
      check_cursor("fill_cur");
      check_all();
      send_char(8'h0C, 1'b1);
      check_all();

      // Reset in the middle of a clear restarts it from the beginning
      for (int i = 0; i < 7; i++) send_char(8'($urandom_range(33, 126)));
      cif.char_in    = 8'h0C;
      cif.char_valid = 1'b1;
      @(posedge VGA_clk);
      @(negedge VGA_clk);
      cif.char_valid = 1'b0;
      repeat (100) @(negedge VGA_clk);
      resetn = 1'b0;
      @(negedge VGA_clk);
      chk("midrst_busy", 32'(busy), 32'd1);
      chk("midrst_col", 32'(cursor_col), 32'd0);
      resetn = 1'b1;
      wait_clear(1'b0);
      check_all();

      // Active-area boundaries
      send_char(8'h0C);
      for (int i = 0; i < CELLS; i++) send_char(8'($urandom_range(33, 126)));
      read_pixel(640, 100);
      read_pixel(100, 480);
      read_pixel(639, 479);
      read_pixel(0, 0);
      read_pixel(1023, 1023);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/text_char_buffer.md
Name: text_char_buffer

Overview:
- Producer side of the glyph renderer interface.
- Accepts an ASCII character stream over a valid/ready handshake and stores it in a COLS x ROWS character-cell RAM, managing a cursor with wrap, newline, backspace and clear.
- For each VGA pixel coordinate it returns the character covering that pixel plus that cell's top-left corner, for direct connection to the glyph mask block's ascii_val/xStart/yStart inputs.

Parameters:
- CELL_LOG2, 5, log2 of square cell size in pixels (32x32 cells; the 22x21 glyph fits).
- COLS, 20, character columns (640 / 32).
- ROWS, 15, character rows (480 / 32).
- H_ACTIVE, 640, visible width in pixels.
- V_ACTIVE, 480, visible height in pixels.

Ports:
- VGA_clk  in  1  pixel clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- char_in  in  8  ASCII code to write.
- char_valid  in  1  char_in valid.
- char_ready  out  1  block can accept char_in this cycle.
- xPixel  in  10  current pixel x.
- yPixel  in  10  current pixel y.
- ascii_val  out  8  character at the pixel's cell; 0x00 outside the active area.
- xStart  out  10  cell left x = col << CELL_LOG2.
- yStart  out  10  cell top y = row << CELL_LOG2.
- cursor_col  out  5  current cursor column.
- cursor_row  out  4  current cursor row.
- busy  out  1  clear in progress.

Behaviour:
- Storage: dual-port RAM, COLS*ROWS x 8. Write port is owned by the FSM; read port is owned by the pixel path. Address = row*COLS + col.
- Reset (async, resetn=0): cursor (0,0); ascii_val/xStart/yStart 0; char_ready 0; busy 1; FSM goes to CLEAR. RAM contents are not reset directly; CLEAR erases them.
- FSM states:
  - CLEAR: writes 0x20 to one address per cycle, 0 to COLS*ROWS-1 (300 cycles at defaults). On the last write: cursor goes to (0,0), then IDLE. char_ready=0 and busy=1 throughout.
  - IDLE: char_ready=1, busy=0. A transfer happens when char_valid && char_ready at a rising edge. Every transfer is consumed in one cycle except 0x0C.
- Transfer decode:
  - 0x20..0x7E: write char at the cursor, then advance. col==COLS-1 wraps to col 0, row+1. The last cell (COLS-1, ROWS-1) wraps to (0,0). No scrolling.
  - 0x0A newline: col goes to 0, row+1; from ROWS-1 it goes to row 0. No RAM write.
  - 0x08 backspace: move the cursor back one cell (col 0 of row r>0 goes to COLS-1 of row r-1), then write 0x20 at the new position. At (0,0): no effect.
  - 0x0C clear: enter CLEAR on the next cycle. char_ready drops the cycle after the transfer.
  - Any other code: consumed, no effect.
- Reset mid-CLEAR restarts CLEAR from address 0.
- Pixel read path, fixed 2-cycle latency (pixel sampled at edge N, outputs valid after edge N+2):
  - Stage 1 registers col = xPixel>>CELL_LOG2, row = yPixel>>CELL_LOG2, and in_area = (xPixel<H_ACTIVE)&&(yPixel<V_ACTIVE).
  - Stage 2 does a synchronous RAM read and registers ascii_val (forced to 0x00 when !in_area) and xStart/yStart (cell origin; 0 when !in_area).
- Read-during-write to the same address returns the old data.
- The pixel path is independent of the FSM. During CLEAR it returns partially cleared contents.

Test Plan:
- Release resetn and wait 300 cycles -> busy falls at cycle 300 and char_ready=1. Sweep all pixels -> every in-area ascii_val=0x20.
- Send "M" (0x4D) then pixel (5,3) -> ascii_val=0x4D, xStart=0, yStart=0 two cycles later; cursor (1,0).
- Send 20 x 0x41 then 0x42 -> cursor (1,1). Pixel (10,40) -> ascii_val=0x42, xStart=0, yStart=32.
- Set cursor to (0,1) via 0x0A, then send 0x08 -> cursor (19,0) and cell (19,0)=0x20. Send 0x08 at (0,0) -> no change.
- Fill all 300 cells -> cursor (0,0). Send 0x0C -> char_ready=0 for 300 cycles, then all cells 0x20. Assert resetn low mid-clear -> clear restarts, total 300 cycles after release.
- Pixel (640,100) and (100,480) -> ascii_val=0x00, xStart=0, yStart=0. Hold char_valid during CLEAR -> no transfer until char_ready=1.
